// File: rtl/microcode_sequencer_if.sv
// rtl/microcode_sequencer_if.sv - microcode ROM fetch and memory handshake bundle
interface microcode_sequencer_if #(
    parameter int AW = 5,
    parameter int UW = 40
);
    logic [AW-1:0] rom_addr;
    logic [UW-1:0] rom_data;
    logic          mem_req;
    logic          mem_ack;

    modport master (output rom_addr, output mem_req, input rom_data, input mem_ack);
    modport slave  (input rom_addr, input mem_req, output rom_data, output mem_ack);
endinterface

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - microcode sequencer with RUN/WAIT/HALT control
// Optional return stack for CALL/RET enabled by macro MICROSEQ_STACK_EN.
module microcode_sequencer #(
    parameter int AW         = 5,
    parameter int NREG       = 12,
    parameter int CW         = 22,
    parameter int RESET_ADDR = 0,
    parameter int STK_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    microcode_sequencer_if.master              bus,
    input  logic                               cond,
    input  logic [AW-1:0]                      opcode,
    input  logic [$clog2(NREG+1)-1:0]          ir_wsel,
    input  logic [$clog2(NREG+1)-1:0]          ir_rsel,
    output logic [NREG-1:0]                    wr_en,
    output logic [NREG-1:0]                    rd_en,
    output logic [CW-1:0]                      ctrl,
    output logic                               halted,
    output logic [AW-1:0]                      upc,
    output logic                               stk_err
);
    localparam int SW       = $clog2(NREG+1);
    localparam int UW       = 5 + 2*SW + CW + AW;
    localparam int CTRL_LSB = AW;
    localparam int RSEL_LSB = AW + CW;
    localparam int WSEL_LSB = RSEL_LSB + SW;
    localparam int M_BIT    = WSEL_LSB + SW;
    localparam int MODE_LSB = M_BIT + 1;
    localparam int SP_BIT   = MODE_LSB + 3;

    localparam logic [2:0] MODE_SEQ  = 3'b000;
    localparam logic [2:0] MODE_BRT  = 3'b001;
    localparam logic [2:0] MODE_BRF  = 3'b010;
    localparam logic [2:0] MODE_DISP = 3'b011;
    localparam logic [2:0] MODE_CALL = 3'b100;
    localparam logic [2:0] MODE_RET  = 3'b101;
    localparam logic [2:0] MODE_HALT = 3'b111;

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;

    state_t        state;
    logic [UW-1:0] uir;
    logic [UW-1:0] f_word;
    logic [2:0]    f_mode;
    logic [AW-1:0] f_nxt;
    logic [AW-1:0] upc_inc;
    logic [AW-1:0] next_addr;
    logic          advance;
    logic          push;
    logic          pop;

    assign bus.rom_addr = upc;
    assign f_mode       = bus.rom_data[MODE_LSB +: 3];
    assign f_nxt        = bus.rom_data[AW-1:0];
    assign upc_inc      = upc + AW'(1);
    assign advance      = (state == S_RUN && !uir[M_BIT]) || (state == S_WAIT && bus.mem_ack);

    // Instruction-register selects replace the ROM selects when SP is set.
    always_comb begin
        f_word = bus.rom_data;
        if (bus.rom_data[SP_BIT]) begin
            f_word[WSEL_LSB +: SW] = ir_wsel;
            f_word[RSEL_LSB +: SW] = ir_rsel;
        end
    end

`ifdef MICROSEQ_STACK_EN
    localparam int CNTW = $clog2(STK_DEPTH+1);
    localparam int IW   = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    logic [AW-1:0]   stk [STK_DEPTH];
    logic [CNTW-1:0] sp_cnt;
    logic [CNTW-1:0] top_idx;
    logic            err_q;

    assign top_idx = sp_cnt - CNTW'(1);
`endif

    always_comb begin
        next_addr = f_nxt;
        push      = 1'b0;
        pop       = 1'b0;
        case (f_mode)
            MODE_BRT:  next_addr = cond ? f_nxt : upc_inc;
            MODE_BRF:  next_addr = cond ? upc_inc : f_nxt;
            MODE_DISP: next_addr = opcode;
`ifdef MICROSEQ_STACK_EN
            MODE_CALL: push = 1'b1;
            MODE_RET: begin
                pop       = 1'b1;
                next_addr = (sp_cnt == '0) ? AW'(RESET_ADDR) : stk[top_idx[IW-1:0]];
            end
`else
            MODE_CALL, MODE_RET: next_addr = f_nxt;
`endif
            MODE_HALT: next_addr = upc;
            default:   next_addr = f_nxt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upc   <= AW'(RESET_ADDR);
            uir   <= '0;
            state <= S_RUN;
        end else begin
            case (state)
                S_RUN, S_WAIT: begin
                    if (advance) begin
                        uir   <= f_word;
                        upc   <= next_addr;
                        state <= (f_mode == MODE_HALT) ? S_HALT : S_RUN;
                    end else if (state == S_RUN) begin
                        state <= S_WAIT;
                    end
                end
                S_HALT:  uir <= '0;
                default: state <= S_RUN;
            endcase
        end
    end

`ifdef MICROSEQ_STACK_EN
    // A full-stack CALL still jumps; an empty-stack RET falls back to the reset address.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_cnt <= '0;
            err_q  <= 1'b0;
        end else if (advance) begin
            if (push) begin
                if (sp_cnt == CNTW'(STK_DEPTH)) begin
                    err_q <= 1'b1;
                end else begin
                    stk[sp_cnt[IW-1:0]] <= upc_inc;
                    sp_cnt              <= sp_cnt + CNTW'(1);
                end
            end else if (pop) begin
                if (sp_cnt == '0) err_q  <= 1'b1;
                else              sp_cnt <= top_idx;
            end
        end
    end

    assign stk_err = err_q;
`else
    assign stk_err = 1'b0;
`endif

    always_comb begin
        wr_en = '0;
        rd_en = '0;
        for (int k = 1; k <= NREG; k++) begin
            if (uir[WSEL_LSB +: SW] == SW'(k)) wr_en[k-1] = 1'b1;
            if (uir[RSEL_LSB +: SW] == SW'(k)) rd_en[k-1] = 1'b1;
        end
    end

    assign ctrl        = uir[CTRL_LSB +: CW];
    assign halted      = (state == S_HALT);
    assign bus.mem_req = uir[M_BIT] && (state == S_RUN || state == S_WAIT);
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - directed self-checking bench for microcode_sequencer
module tb_microcode_sequencer;
    localparam int AW   = 5;
    localparam int NREG = 12;
    localparam int CW   = 22;
    localparam int SW   = 4;
    localparam int UW   = 5 + 2*SW + CW + AW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cond = 1'b0;
    logic [AW-1:0]   opcode = '0;
    logic [SW-1:0]   ir_wsel = '0;
    logic [SW-1:0]   ir_rsel = '0;
    logic [NREG-1:0] wr_en;
    logic [NREG-1:0] rd_en;
    logic [CW-1:0]   ctrl;
    logic            halted;
    logic [AW-1:0]   upc;
    logic            stk_err;
    logic [UW-1:0]   rom [32];
    int              checks = 0;
    int              failures = 0;

    always #5 clk = ~clk;

    microcode_sequencer_if #(.AW(AW), .UW(UW)) bus ();
    assign bus.rom_data = rom[bus.rom_addr];

    microcode_sequencer #(
        .AW(AW), .NREG(NREG), .CW(CW), .RESET_ADDR(0), .STK_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.master), .cond(cond), .opcode(opcode),
        .ir_wsel(ir_wsel), .ir_rsel(ir_rsel), .wr_en(wr_en), .rd_en(rd_en),
        .ctrl(ctrl), .halted(halted), .upc(upc), .stk_err(stk_err)
    );

    function automatic logic [UW-1:0] mk(input logic sp, input logic [2:0] mode, input logic m,
                                         input logic [SW-1:0] ws, input logic [SW-1:0] rs,
                                         input logic [CW-1:0] c, input logic [AW-1:0] nxt);
        return {sp, mode, m, ws, rs, c, nxt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = '0;
        rom[0]  = mk(0, 3'd0, 0, 4'd3, 4'd0,  22'h3,   5'd5);
        rom[5]  = mk(0, 3'd0, 0, 4'd0, 4'd12, 22'h155, 5'd31);
        rom[31] = mk(0, 3'd1, 0, 4'd13, 4'd0, 22'h7,   5'd9);
        rom[9]  = mk(0, 3'd2, 0, 4'd0, 4'd0,  22'h9,   5'd12);
        rom[10] = mk(0, 3'd0, 1, 4'd0, 4'd0,  22'hA,   5'd14);
        rom[14] = mk(1, 3'd0, 0, 4'd1, 4'd2,  22'hE,   5'd15);
        rom[15] = mk(0, 3'd3, 0, 4'd0, 4'd0,  22'hF,   5'd0);
        rom[18] = mk(0, 3'd0, 0, 4'd0, 4'd0,  22'h12,  5'd4);
        rom[4]  = mk(0, 3'd4, 0, 4'd0, 4'd0,  22'h4,   5'd20);
        rom[20] = mk(0, 3'd5, 0, 4'd0, 4'd0,  22'h14,  5'd22);
        rom[22] = mk(0, 3'd7, 0, 4'd2, 4'd0,  22'h16,  5'd0);

        step();
        chk("rst_upc", 32'(upc), 0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_ctrl", 32'(ctrl), 0);
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_stk_err", 32'(stk_err), 0);
        rst = 1'b0;

        step();
        chk("seq_rom_addr", 32'(bus.rom_addr), 5);
        chk("seq_wr_en", 32'(wr_en), 'h4);
        chk("seq_ctrl", 32'(ctrl), 'h3);
        step();
        chk("seq_upc31", 32'(upc), 31);
        chk("rsel12_rd_en", 32'(rd_en), 'h800);
        chk("seq_wr_zero", 32'(wr_en), 0);
        cond = 1'b0;
        step();
        chk("brt_nt_wrap", 32'(upc), 0);
        chk("wsel_over_nreg", 32'(wr_en), 0);
        chk("brt_ctrl", 32'(ctrl), 'h7);
        step();
        step();
        chk("loop_upc31", 32'(upc), 31);
        cond = 1'b1;
        step();
        chk("brt_taken", 32'(upc), 9);
        step();
        chk("brf_nt", 32'(upc), 10);
        chk("brf_ctrl", 32'(ctrl), 'h9);

        step();
        chk("mem_word_upc", 32'(upc), 14);
        chk("mem_req_run", 32'(bus.mem_req), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_upc", 32'(upc), 14);
            chk("wait_ctrl", 32'(ctrl), 'hA);
            chk("wait_mem_req", 32'(bus.mem_req), 1);
        end
        bus.mem_ack = 1'b1;
        ir_wsel = 4'd7;
        ir_rsel = 4'd0;
        step();
        bus.mem_ack = 1'b0;
        chk("ack_upc", 32'(upc), 15);
        chk("ack_mem_req", 32'(bus.mem_req), 0);
        chk("sp_wr_en", 32'(wr_en), 'h40);
        chk("sp_rd_en", 32'(rd_en), 0);
        chk("sp_ctrl", 32'(ctrl), 'hE);

        opcode = 5'h12;
        step();
        chk("dispatch_upc", 32'(upc), 'h12);
        step();
        chk("seq_to_call", 32'(upc), 4);
        step();
        chk("call_upc", 32'(upc), 20);
        chk("call_ctrl", 32'(ctrl), 'h4);
        step();
`ifdef MICROSEQ_STACK_EN
        chk("ret_upc", 32'(upc), 5);
`else
        chk("ret_as_seq_upc", 32'(upc), 22);
`endif
        chk("ret_ctrl", 32'(ctrl), 'h14);
        chk("ret_stk_err", 32'(stk_err), 0);

        rst = 1'b1;
        rom[0] = mk(0, 3'd0, 1, 4'd0, 4'd0, 22'h21, 5'd3);
        step();
        rst = 1'b0;
        step();
        chk("w2_upc", 32'(upc), 3);
        chk("w2_mem_req", 32'(bus.mem_req), 1);
        step();
        chk("w2_wait_req", 32'(bus.mem_req), 1);
        rst = 1'b1;
        step();
        chk("rst_wait_req", 32'(bus.mem_req), 0);
        chk("rst_wait_upc", 32'(upc), 0);
        chk("rst_wait_ctrl", 32'(ctrl), 0);

        rom[0] = mk(0, 3'd0, 0, 4'd0, 4'd0, 22'h1, 5'd22);
        rst = 1'b0;
        step();
        chk("h_pre_upc", 32'(upc), 22);
        step();
        chk("h_latch_upc", 32'(upc), 22);
        chk("h_latch_ctrl", 32'(ctrl), 'h16);
        chk("h_latch_wr", 32'(wr_en), 'h2);
        step();
        chk("h_halted", 32'(halted), 1);
        chk("h_ctrl_clr", 32'(ctrl), 0);
        chk("h_wr_clr", 32'(wr_en), 0);
        chk("h_upc_hold", 32'(upc), 22);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("h_ack_ignored", 32'(upc), 22);
        chk("h_still_halted", 32'(halted), 1);
        chk("h_mem_req", 32'(bus.mem_req), 0);
        rst = 1'b1;
        step();
        chk("h_rst_upc", 32'(upc), 0);
        chk("h_rst_halted", 32'(halted), 0);
        chk("h_rst_ctrl", 32'(ctrl), 0);

`ifdef MICROSEQ_STACK_EN
        rom[0] = mk(0, 3'd4, 0, 4'd0, 4'd0, 22'h30, 5'd1);
        rom[1] = mk(0, 3'd4, 0, 4'd0, 4'd0, 22'h31, 5'd2);
        rom[2] = mk(0, 3'd4, 0, 4'd0, 4'd0, 22'h32, 5'd3);
        rom[3] = mk(0, 3'd4, 0, 4'd0, 4'd0, 22'h33, 5'd6);
        rom[6] = mk(0, 3'd4, 0, 4'd0, 4'd0, 22'h36, 5'd7);
        rom[7] = mk(0, 3'd5, 0, 4'd0, 4'd0, 22'h37, 5'd0);
        rst = 1'b0;
        step();
        step();
        step();
        chk("nest3_upc", 32'(upc), 3);
        step();
        chk("nest4_upc", 32'(upc), 6);
        chk("nest4_err", 32'(stk_err), 0);
        step();
        chk("nest5_upc", 32'(upc), 7);
        chk("nest5_err", 32'(stk_err), 1);
        step();
        chk("pop_upc", 32'(upc), 4);
        chk("err_sticky", 32'(stk_err), 1);
        rst = 1'b1;
        rom[0] = mk(0, 3'd5, 0, 4'd0, 4'd0, 22'h40, 5'd9);
        step();
        chk("err_rst", 32'(stk_err), 0);
        rst = 1'b0;
        step();
        chk("ret_empty_upc", 32'(upc), 0);
        chk("ret_empty_err", 32'(stk_err), 1);
`else
        chk("stk_err_tied", 32'(stk_err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
